deparser: RTL and testbench

- Packet deparser: the emit-side counterpart of the header parser.
- Takes per-header start addresses produced by the parser (`parsed_hdrs`) and serialises those headers, in header-id order, into a contiguous output buffer through the same single-port memory interface. A header is skipped when it is absent.
- Header lengths are held in an internal table, programmed over the same modify interface style the parser uses.
- Sits after the match-action stage; its `ready_o` hands the rebuilt packet to the egress logic.

---
 rtl/deparser.sv | 201 ++++++++++++++++++++
 tb/tb_deparser.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/deparser.sv
// Packet deparser: copies each present header, in header-id order, from its parsed
// source address into a contiguous output buffer in chunks of up to 4 bytes.
module deparser #(
  parameter int          NUM_HEADERS = 2,
  parameter logic [31:0] NO_HEADER   = 32'hFFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [31:0]               out_addr_i,
  input  logic [32*NUM_HEADERS-1:0] hdr_addrs_i,
  input  logic                      mod_start_i,
  input  logic [31:0]               mod_hdr_id_i,
  input  logic [31:0]               mod_hdr_len_i,
  output logic                      mem_ce_o,
  output logic                      mem_we_o,
  output logic [31:0]               mem_addr_o,
  output logic [3:0]                mem_width_o,
  output logic [31:0]               mem_data_o,
  input  logic [31:0]               mem_data_i,
  output logic                      ready_o,
  output logic [31:0]               out_len_o
);

  localparam int IDX_W = $clog2(NUM_HEADERS + 1);

  typedef enum logic [2:0] {FREE, SCAN, READ, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       lenTab_q [NUM_HEADERS];
  logic [31:0]       lenTab_d [NUM_HEADERS];
  logic [31:0]       hdrAddr_q [NUM_HEADERS];
  logic [31:0]       hdrAddr_d [NUM_HEADERS];
  logic [31:0]       outBase_q, outBase_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       outOff_q, outOff_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       rem_q, rem_d;
  logic [3:0]        width_q, width_d;
  logic              memCe_q, memCe_d;
  logic              memWe_q, memWe_d;
  logic [31:0]       memAddr_q, memAddr_d;
  logic [3:0]        memWidth_q, memWidth_d;
  logic [31:0]       memData_q, memData_d;
  logic              ready_q, ready_d;
  logic [31:0]       outLen_q, outLen_d;
  logic [31:0]       curAddr, curLen;

  function automatic logic [3:0] chunkWidth(input logic [31:0] r);
    return (r >= 32'd4) ? 4'd4 : r[3:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FREE;
      for (int i = 0; i < NUM_HEADERS; i++) begin
        lenTab_q[i]  <= '0;
        hdrAddr_q[i] <= '0;
      end
      outBase_q  <= '0;
      idx_q      <= '0;
      outOff_q   <= '0;
      src_q      <= '0;
      rem_q      <= '0;
      width_q    <= '0;
      memCe_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWidth_q <= '0;
      memData_q  <= '0;
      ready_q    <= 1'b0;
      outLen_q   <= '0;
    end else begin
      state_q    <= state_d;
      lenTab_q   <= lenTab_d;
      hdrAddr_q  <= hdrAddr_d;
      outBase_q  <= outBase_d;
      idx_q      <= idx_d;
      outOff_q   <= outOff_d;
      src_q      <= src_d;
      rem_q      <= rem_d;
      width_q    <= width_d;
      memCe_q    <= memCe_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWidth_q <= memWidth_d;
      memData_q  <= memData_d;
      ready_q    <= ready_d;
      outLen_q   <= outLen_d;
    end
  end

  // Each chunk is a read presented on one edge and the matching write on the next;
  // the write data is whatever the memory returned during the read cycle.
  always_comb begin
    state_d    = state_q;
    lenTab_d   = lenTab_q;
    hdrAddr_d  = hdrAddr_q;
    outBase_d  = outBase_q;
    idx_d      = idx_q;
    outOff_d   = outOff_q;
    src_d      = src_q;
    rem_d      = rem_q;
    width_d    = width_q;
    memCe_d    = memCe_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWidth_d = memWidth_q;
    memData_d  = memData_q;
    ready_d    = ready_q;
    outLen_d   = outLen_q;
    curAddr    = '0;
    curLen     = '0;
    for (int i = 0; i < NUM_HEADERS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        curAddr = hdrAddr_q[i];
        curLen  = lenTab_q[i];
      end
    end

    case (state_q)
      FREE: begin
        if (mod_start_i) begin
          for (int i = 0; i < NUM_HEADERS; i++) begin
            if (mod_hdr_id_i == 32'(i)) lenTab_d[i] = mod_hdr_len_i;
          end
        end else if (start_i) begin
          for (int i = 0; i < NUM_HEADERS; i++) begin
            hdrAddr_d[i] = hdr_addrs_i[32*i +: 32];
          end
          outBase_d = out_addr_i;
          idx_d     = '0;
          outOff_d  = '0;
          ready_d   = 1'b0;
          outLen_d  = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_HEADERS)) begin
          memCe_d  = 1'b0;
          ready_d  = 1'b1;
          outLen_d = outOff_q;
          state_d  = DONE;
        end else if (curAddr == NO_HEADER || curLen == 32'd0) begin
          idx_d   = idx_q + 1'b1;
          memCe_d = 1'b0;
        end else begin
          src_d      = curAddr;
          rem_d      = curLen;
          width_d    = chunkWidth(curLen);
          memCe_d    = 1'b1;
          memWe_d    = 1'b0;
          memAddr_d  = curAddr;
          memWidth_d = chunkWidth(curLen);
          state_d    = WRITE;
        end
      end
      WRITE: begin
        memCe_d    = 1'b1;
        memWe_d    = 1'b1;
        memAddr_d  = outBase_q + outOff_q;
        memWidth_d = width_q;
        memData_d  = mem_data_i;
        src_d      = src_q + {28'd0, width_q};
        outOff_d   = outOff_q + {28'd0, width_q};
        rem_d      = rem_q - {28'd0, width_q};
        if (rem_q == {28'd0, width_q}) begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        width_d    = chunkWidth(rem_q);
        memCe_d    = 1'b1;
        memWe_d    = 1'b0;
        memAddr_d  = src_q;
        memWidth_d = chunkWidth(rem_q);
        state_d    = WRITE;
      end
      DONE: begin
        if (!start_i) begin
          ready_d = 1'b0;
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  assign mem_ce_o    = memCe_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_width_o = memWidth_q;
  assign mem_data_o  = memData_q;
  assign ready_o     = ready_q;
  assign out_len_o   = outLen_q;

endmodule

// File: tb/tb_deparser.sv
// Directed bench for the deparser: a behavioural read-only memory returns an
// address-derived word, so every write can be checked against its source address.
module tb_deparser;

  localparam int          NUM_HEADERS = 2;
  localparam logic [31:0] NO_HEADER   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] out_addr_i;
  logic [63:0] hdr_addrs_i;
  logic        mod_start_i;
  logic [31:0] mod_hdr_id_i;
  logic [31:0] mod_hdr_len_i;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_width_o;
  logic [31:0] mem_data_o;
  logic [31:0] memDataIn;
  logic        ready_o;
  logic [31:0] out_len_o;

  int compared   = 0;
  int mismatched = 0;

  deparser #(.NUM_HEADERS(NUM_HEADERS), .NO_HEADER(NO_HEADER)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .out_addr_i(out_addr_i),
    .hdr_addrs_i(hdr_addrs_i), .mod_start_i(mod_start_i),
    .mod_hdr_id_i(mod_hdr_id_i), .mod_hdr_len_i(mod_hdr_len_i),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(memDataIn),
    .ready_o(ready_o), .out_len_o(out_len_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign memDataIn = (mem_ce_o && !mem_we_o) ? memWord(mem_addr_o) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic startVal, input logic [31:0] hdr0,
                               input logic [31:0] hdr1, input logic [31:0] outAddr);
    start_i     = startVal;
    hdr_addrs_i = {hdr1, hdr0};
    out_addr_i  = outAddr;
  endtask

  task automatic programLen(input logic [31:0] id, input logic [31:0] len);
    mod_start_i   = 1'b1;
    mod_hdr_id_i  = id;
    mod_hdr_len_i = len;
    tick();
    mod_start_i   = 1'b0;
  endtask

  task automatic expectRead(input string tag, input logic [31:0] addr, input logic [3:0] w);
    tick();
    checkOutput({tag, " rd ce"}, {31'd0, mem_ce_o}, 32'd1);
    checkOutput({tag, " rd we"}, {31'd0, mem_we_o}, 32'd0);
    checkOutput({tag, " rd addr"}, mem_addr_o, addr);
    checkOutput({tag, " rd width"}, {28'd0, mem_width_o}, {28'd0, w});
  endtask

  task automatic expectWrite(input string tag, input logic [31:0] addr, input logic [3:0] w,
                             input logic [31:0] data);
    tick();
    checkOutput({tag, " wr ce"}, {31'd0, mem_ce_o}, 32'd1);
    checkOutput({tag, " wr we"}, {31'd0, mem_we_o}, 32'd1);
    checkOutput({tag, " wr addr"}, mem_addr_o, addr);
    checkOutput({tag, " wr width"}, {28'd0, mem_width_o}, {28'd0, w});
    checkOutput({tag, " wr data"}, mem_data_o, data);
  endtask

  task automatic expectIdle(input string tag, input logic rdy, input logic [31:0] len);
    checkOutput({tag, " ce"}, {31'd0, mem_ce_o}, 32'd0);
    checkOutput({tag, " ready"}, {31'd0, ready_o}, {31'd0, rdy});
    checkOutput({tag, " out_len"}, out_len_o, len);
  endtask

  initial begin
    rst           = 1'b1;
    mod_start_i   = 1'b0;
    mod_hdr_id_i  = '0;
    mod_hdr_len_i = '0;
    applyStimulus(1'b0, '0, '0, '0);
    tick();
    expectIdle("reset", 1'b0, 32'd0);
    checkOutput("reset we", {31'd0, mem_we_o}, 32'd0);
    checkOutput("reset addr", mem_addr_o, 32'd0);
    checkOutput("reset width", {28'd0, mem_width_o}, 32'd0);
    checkOutput("reset data", mem_data_o, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // single 4-byte header, second header absent
    $display("[TB] one 4-byte header");
    programLen(0, 4);
    programLen(1, 0);
    applyStimulus(1'b1, 32'h100, NO_HEADER, 32'h800);
    tick();
    start_i = 1'b0;
    expectIdle("t1 scan", 1'b0, 32'd0);
    expectRead("t1", 32'h100, 4'd4);
    expectWrite("t1", 32'h800, 4'd4, memWord(32'h100));
    tick();
    expectIdle("t1 skip", 1'b0, 32'd0);
    tick();
    expectIdle("t1 done", 1'b1, 32'd4);
    tick();
    expectIdle("t1 free", 1'b0, 32'd4);

    // 14 + 20 bytes, start held high through DONE
    $display("[TB] two headers, 14 and 20 bytes");
    programLen(0, 14);
    programLen(1, 20);
    applyStimulus(1'b1, 32'h100, 32'h10E, 32'h800);
    tick();
    for (int k = 0; k < 3; k++) begin
      expectRead("t2 h0", 32'h100 + 32'(4*k), 4'd4);
      expectWrite("t2 h0", 32'h800 + 32'(4*k), 4'd4, memWord(32'h100 + 32'(4*k)));
    end
    expectRead("t2 h0 tail", 32'h10C, 4'd2);
    expectWrite("t2 h0 tail", 32'h80C, 4'd2, memWord(32'h10C));
    for (int k = 0; k < 5; k++) begin
      expectRead("t2 h1", 32'h10E + 32'(4*k), 4'd4);
      expectWrite("t2 h1", 32'h80E + 32'(4*k), 4'd4, memWord(32'h10E + 32'(4*k)));
    end
    tick();
    expectIdle("t2 done", 1'b1, 32'd34);
    for (int k = 0; k < 3; k++) begin
      tick();
      expectIdle("t2 hold", 1'b1, 32'd34);
    end
    start_i = 1'b0;
    tick();
    expectIdle("t2 release", 1'b0, 32'd34);

    // header 0 absent, header 1 is 6 bytes
    $display("[TB] header 0 absent");
    programLen(1, 6);
    applyStimulus(1'b1, NO_HEADER, 32'h200, 32'hA00);
    tick();
    start_i = 1'b0;
    tick();
    expectIdle("t3 skip", 1'b0, 32'd0);
    expectRead("t3", 32'h200, 4'd4);
    expectWrite("t3", 32'hA00, 4'd4, memWord(32'h200));
    expectRead("t3 tail", 32'h204, 4'd2);
    expectWrite("t3 tail", 32'hA04, 4'd2, memWord(32'h204));
    tick();
    expectIdle("t3 done", 1'b1, 32'd6);
    tick();

    // table write wins over start; busy-time table writes are dropped
    $display("[TB] mod_start priority");
    mod_start_i   = 1'b1;
    mod_hdr_id_i  = 0;
    mod_hdr_len_i = 8;
    applyStimulus(1'b1, 32'h300, NO_HEADER, 32'hB00);
    tick();
    tick();
    expectIdle("t4 free", 1'b0, 32'd6);
    mod_start_i = 1'b0;
    tick();
    mod_start_i   = 1'b1;
    mod_hdr_len_i = 100;
    expectRead("t4", 32'h300, 4'd4);
    expectWrite("t4", 32'hB00, 4'd4, memWord(32'h300));
    expectRead("t4 b", 32'h304, 4'd4);
    expectWrite("t4 b", 32'hB04, 4'd4, memWord(32'h304));
    mod_start_i = 1'b0;
    tick();
    tick();
    expectIdle("t4 done", 1'b1, 32'd8);
    start_i = 1'b0;
    tick();
    applyStimulus(1'b1, 32'h400, NO_HEADER, 32'hC00);
    tick();
    start_i = 1'b0;
    expectRead("t4 len", 32'h400, 4'd4);
    expectWrite("t4 len", 32'hC00, 4'd4, memWord(32'h400));
    expectRead("t4 len b", 32'h404, 4'd4);
    expectWrite("t4 len b", 32'hC04, 4'd4, memWord(32'h404));
    tick();
    expectIdle("t4 unchanged", 1'b0, 32'd0);
    tick();
    tick();

    // asynchronous reset in the middle of a WRITE cycle
    $display("[TB] reset mid-packet");
    applyStimulus(1'b1, 32'h500, NO_HEADER, 32'hD00);
    tick();
    start_i = 1'b0;
    expectRead("t5", 32'h500, 4'd4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5 async ce", {31'd0, mem_ce_o}, 32'd0);
    checkOutput("t5 async ready", {31'd0, ready_o}, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h500, 32'h600, 32'hD00);
    tick();
    start_i = 1'b0;
    tick();
    expectIdle("t5 skip0", 1'b0, 32'd0);
    tick();
    expectIdle("t5 skip1", 1'b0, 32'd0);
    tick();
    expectIdle("t5 done", 1'b1, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
